// File: rtl/simd_adder_pipe_if.sv
// Handshake and operand bundle for simd_adder_pipe: producer beat in, result beat out.
interface simd_adder_pipe_if #(
    parameter int MIN_WIDTH = 8,
    parameter int MAX_WIDTH = 64,
    parameter int SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1,
    parameter int TAG_WIDTH = 4
);
    localparam int RATIO = MAX_WIDTH / MIN_WIDTH;

    logic                 valid_i;
    logic                 ready_o;
    logic                 sub_i;
    logic                 rev_i;
    logic                 carry_i;
    logic                 sat_i;
    logic                 signed_i;
    logic [SEW_WIDTH-1:0] sew_i;
    logic [RATIO-1:0]     mask_i;
    logic [MAX_WIDTH-1:0] opA_i;
    logic [MAX_WIDTH-1:0] opB_i;
    logic [TAG_WIDTH-1:0] tag_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [MAX_WIDTH-1:0] result_o;
    logic [RATIO-1:0]     carry_o;
    logic [RATIO-1:0]     ovf_o;
    logic [TAG_WIDTH-1:0] tag_o;
    logic                 vxsat_o;
    logic                 clr_vxsat_i;

    modport master (
        output valid_i, sub_i, rev_i, carry_i, sat_i, signed_i, sew_i, mask_i,
               opA_i, opB_i, tag_i, ready_i, clr_vxsat_i,
        input  ready_o, valid_o, result_o, carry_o, ovf_o, tag_o, vxsat_o
    );

    modport slave (
        input  valid_i, sub_i, rev_i, carry_i, sat_i, signed_i, sew_i, mask_i,
               opA_i, opB_i, tag_i, ready_i, clr_vxsat_i,
        output ready_o, valid_o, result_o, carry_o, ovf_o, tag_o, vxsat_o
    );
endinterface

// File: rtl/simd_adder_pipe.sv
// Packed SIMD adder/subtractor with per-element carry-in, saturation and a 1- or 2-stage
// pipeline; element width is chosen per beat, carries never cross element boundaries.
module simd_adder_pipe #(
    parameter int MIN_WIDTH = 8,
    parameter int MAX_WIDTH = 64,
    parameter int SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1,
    parameter int STAGES    = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    simd_adder_pipe_if.slave  bus
);
    localparam int RATIO     = MAX_WIDTH / MIN_WIDTH;
    localparam int LOG_RATIO = $clog2(RATIO);
    localparam int IDXW      = (RATIO > 1) ? LOG_RATIO : 1;

    // Returns (chunks per element - 1); the highest set sew bit selects MAX_WIDTH >> i.
    function automatic logic [IDXW-1:0] sew_to_mask(input logic [SEW_WIDTH-1:0] sew);
        logic [IDXW-1:0] m;
        m = IDXW'(RATIO - 1);
        for (int i = 0; i < SEW_WIDTH; i++) begin
            m = (sew[i] && (i <= LOG_RATIO)) ? IDXW'((RATIO >> i) - 1) : m;
        end
        return m;
    endfunction

    logic                 advance_s;
    logic                 use_mask_s;
    logic [MAX_WIDTH-1:0] s1_a_d;
    logic [MAX_WIDTH-1:0] s1_b_d;
    logic [RATIO-1:0]     s1_cin_d;
    logic [IDXW-1:0]      s1_mask_d;

    logic                 op_valid_s;
    logic [MAX_WIDTH-1:0] op_a_s;
    logic [MAX_WIDTH-1:0] op_b_s;
    logic [RATIO-1:0]     op_cin_s;
    logic [IDXW-1:0]      op_mask_s;
    logic                 op_sub_s;
    logic                 op_sat_s;
    logic                 op_sgn_s;
    logic [TAG_WIDTH-1:0] op_tag_s;

    logic [MAX_WIDTH-1:0] raw_s;
    logic [MAX_WIDTH-1:0] result_d;
    logic [RATIO-1:0]     carry_d;
    logic [RATIO-1:0]     ovf_d;
    logic [RATIO-1:0]     sign_a_s;
    logic [MIN_WIDTH:0]   sum_s;
    logic [MIN_WIDTH-1:0] a_ch_s;
    logic [MIN_WIDTH-1:0] b_ch_s;
    logic [MIN_WIDTH-1:0] sat_ch_s;
    logic [IDXW-1:0]      top_s;
    logic                 chain_s;
    logic                 cin_s;
    logic                 vxsat_d;

    logic                 valid_q;
    logic [MAX_WIDTH-1:0] result_q;
    logic [RATIO-1:0]     carry_q;
    logic [RATIO-1:0]     ovf_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 vxsat_q;

    // The whole pipe moves as one whenever the output slot is empty or being drained.
    assign advance_s  = ~valid_q | bus.ready_i;
    assign use_mask_s = bus.carry_i & ~bus.sat_i;

    // Operand prep: swap, invert for subtract, place carry-in at each element's low chunk.
    always_comb begin
        s1_a_d    = bus.rev_i ? bus.opB_i : bus.opA_i;
        s1_b_d    = (bus.rev_i ? bus.opA_i : bus.opB_i) ^ {MAX_WIDTH{bus.sub_i}};
        s1_mask_d = sew_to_mask(bus.sew_i);
        s1_cin_d  = '0;
        for (int c = 0; c < RATIO; c++) begin
            s1_cin_d[c] = ((IDXW'(c) & s1_mask_d) == '0) ?
                          (use_mask_s ? bus.mask_i[c] : bus.sub_i) : 1'b0;
        end
    end

    generate
        if (STAGES == 2) begin : g_two_stage
            logic                 s1_valid_q;
            logic [MAX_WIDTH-1:0] s1_a_q;
            logic [MAX_WIDTH-1:0] s1_b_q;
            logic [RATIO-1:0]     s1_cin_q;
            logic [IDXW-1:0]      s1_mask_q;
            logic                 s1_sub_q;
            logic                 s1_sat_q;
            logic                 s1_sgn_q;
            logic [TAG_WIDTH-1:0] s1_tag_q;

            // Prepared-operand register; a bubble enters as valid=0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                    s1_a_q     <= '0;
                    s1_b_q     <= '0;
                    s1_cin_q   <= '0;
                    s1_mask_q  <= '0;
                    s1_sub_q   <= 1'b0;
                    s1_sat_q   <= 1'b0;
                    s1_sgn_q   <= 1'b0;
                    s1_tag_q   <= '0;
                end else if (advance_s) begin
                    s1_valid_q <= bus.valid_i;
                    s1_a_q     <= s1_a_d;
                    s1_b_q     <= s1_b_d;
                    s1_cin_q   <= s1_cin_d;
                    s1_mask_q  <= s1_mask_d;
                    s1_sub_q   <= bus.sub_i;
                    s1_sat_q   <= bus.sat_i;
                    s1_sgn_q   <= bus.signed_i;
                    s1_tag_q   <= bus.tag_i;
                end
            end

            assign op_valid_s = s1_valid_q;
            assign op_a_s     = s1_a_q;
            assign op_b_s     = s1_b_q;
            assign op_cin_s   = s1_cin_q;
            assign op_mask_s  = s1_mask_q;
            assign op_sub_s   = s1_sub_q;
            assign op_sat_s   = s1_sat_q;
            assign op_sgn_s   = s1_sgn_q;
            assign op_tag_s   = s1_tag_q;
        end else begin : g_one_stage
            assign op_valid_s = bus.valid_i;
            assign op_a_s     = s1_a_d;
            assign op_b_s     = s1_b_d;
            assign op_cin_s   = s1_cin_d;
            assign op_mask_s  = s1_mask_d;
            assign op_sub_s   = bus.sub_i;
            assign op_sat_s   = bus.sat_i;
            assign op_sgn_s   = bus.signed_i;
            assign op_tag_s   = bus.tag_i;
        end
    endgenerate

    // Segmented chunk adder; the carry chain restarts at every element's low chunk.
    always_comb begin
        raw_s    = '0;
        result_d = '0;
        carry_d  = '0;
        ovf_d    = '0;
        sign_a_s = '0;
        sum_s    = '0;
        a_ch_s   = '0;
        b_ch_s   = '0;
        sat_ch_s = '0;
        top_s    = '0;
        chain_s  = 1'b0;
        cin_s    = 1'b0;
        for (int c = 0; c < RATIO; c++) begin
            a_ch_s = op_a_s[c*MIN_WIDTH +: MIN_WIDTH];
            b_ch_s = op_b_s[c*MIN_WIDTH +: MIN_WIDTH];
            cin_s  = ((IDXW'(c) & op_mask_s) == '0) ? op_cin_s[c] : chain_s;
            sum_s  = {1'b0, a_ch_s} + {1'b0, b_ch_s} + {{MIN_WIDTH{1'b0}}, cin_s};
            raw_s[c*MIN_WIDTH +: MIN_WIDTH] = sum_s[MIN_WIDTH-1:0];
            chain_s = sum_s[MIN_WIDTH];
            if ((IDXW'(c) & op_mask_s) == op_mask_s) begin
                carry_d[c]  = sum_s[MIN_WIDTH];
                sign_a_s[c] = a_ch_s[MIN_WIDTH-1];
                ovf_d[c]    = op_sat_s & (op_sgn_s ?
                              ((a_ch_s[MIN_WIDTH-1] == b_ch_s[MIN_WIDTH-1]) &&
                               (sum_s[MIN_WIDTH-1] != a_ch_s[MIN_WIDTH-1])) :
                              (sum_s[MIN_WIDTH] ^ op_sub_s));
            end else begin
                carry_d[c]  = 1'b0;
                sign_a_s[c] = 1'b0;
                ovf_d[c]    = 1'b0;
            end
        end
        // Each chunk takes its element's verdict from the element's top chunk.
        for (int c = 0; c < RATIO; c++) begin
            top_s    = IDXW'(c) | op_mask_s;
            sat_ch_s = op_sgn_s ?
                       ((IDXW'(c) == top_s) ?
                        {sign_a_s[top_s], {(MIN_WIDTH-1){~sign_a_s[top_s]}}} :
                        {MIN_WIDTH{~sign_a_s[top_s]}}) :
                       {MIN_WIDTH{~op_sub_s}};
            result_d[c*MIN_WIDTH +: MIN_WIDTH] = ovf_d[top_s] ? sat_ch_s :
                                                 raw_s[c*MIN_WIDTH +: MIN_WIDTH];
        end
    end

    // Sticky saturation flag; clear beats a coincident set.
    always_comb begin
        if (bus.clr_vxsat_i) begin
            vxsat_d = 1'b0;
        end else if (valid_q && bus.ready_i && (|ovf_q)) begin
            vxsat_d = 1'b1;
        end else begin
            vxsat_d = vxsat_q;
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= '0;
            ovf_q    <= '0;
            tag_q    <= '0;
        end else if (advance_s) begin
            valid_q  <= op_valid_s;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            tag_q    <= op_tag_s;
        end
    end

    // Saturation status register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vxsat_q <= 1'b0;
        end else begin
            vxsat_q <= vxsat_d;
        end
    end

    assign bus.ready_o  = advance_s;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
    assign bus.carry_o  = carry_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.tag_o    = tag_q;
    assign bus.vxsat_o  = vxsat_q;
endmodule

// File: tb/tb_simd_adder_pipe.sv
// Directed-vector bench for simd_adder_pipe (defaults: 64-bit datapath, 8-bit chunks, 2 stages).
module tb_simd_adder_pipe;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic vx_model;

    typedef struct {
        logic [3:0]  sew;
        logic        sub;
        logic        rev;
        logic        cy;
        logic        sat;
        logic        sgn;
        logic [7:0]  mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [7:0]  cout;
        logic [7:0]  ovf;
        logic [3:0]  tag;
    } vec_t;

    vec_t vecs [13];

    simd_adder_pipe_if bus ();

    simd_adder_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        bus.sew_i    = v.sew;
        bus.sub_i    = v.sub;
        bus.rev_i    = v.rev;
        bus.carry_i  = v.cy;
        bus.sat_i    = v.sat;
        bus.signed_i = v.sgn;
        bus.mask_i   = v.mask;
        bus.opA_i    = v.a;
        bus.opB_i    = v.b;
        bus.tag_i    = v.tag;
    endtask

    // Sends one beat into an idle pipe and returns at the negedge its result is visible.
    task automatic do_beat(input vec_t v);
        @(negedge clk);
        drive_vec(v);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        #1;
        check_val("ready_idle", 64'(bus.ready_o), 64'd1);
        @(negedge clk);
        bus.valid_i = 1'b0;
        check_val("lat_stage1", 64'(bus.valid_o), 64'd0);
        @(negedge clk);
        check_val("lat_valid", 64'(bus.valid_o), 64'd1);
    endtask

    initial begin
        int          send_idx;
        int          recv_idx;
        logic        prev_stall;
        logic [63:0] snap_res;
        logic [3:0]  snap_tag;

        n_checks = 0;
        n_errors = 0;
        vx_model = 1'b0;
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.clr_vxsat_i = 1'b0;
        drive_vec('{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0, 64'd0, 8'h00, 8'h00, 4'h0});

        //              sew     sub   rev   cy    sat   sgn   mask   a                       b                       result                  carry  ovf    tag
        vecs[0]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 64'h0000_0000_0000_0000, 8'h55, 8'h00, 4'h1};
        vecs[1]  = '{4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'd5,                   64'd3,                   64'hFFFF_FFFF_FFFF_FFFE, 8'h00, 8'h00, 4'h2};
        vecs[2]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 64'h7FF0_7FF0_7FF0_7FF0, 64'h0020_0020_0020_0020, 64'h7FFF_7FFF_7FFF_7FFF, 8'h00, 8'hAA, 4'h3};
        vecs[3]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 64'd0,                   64'd0,                   64'h0000_0001_0000_0001, 8'h00, 8'h00, 4'h4};
        vecs[4]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0000_0000_0000_F0FF, 64'h0000_0000_0000_2001, 64'h0000_0000_0000_FFFF, 8'h03, 8'h03, 4'h5};
        vecs[5]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0000_0000_0005_0010, 64'h0000_0000_0010_0005, 64'h0000_0000_0000_000B, 8'hA2, 8'h08, 4'h6};
        vecs[6]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 64'h0000_0003_8000_0000, 64'h0000_0001_0000_0001, 64'h0000_0002_8000_0000, 8'h88, 8'h08, 4'h7};
        vecs[7]  = '{4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0000_0000_0000_00FF, 64'd1,                   64'h0000_0000_0000_0000, 8'h01, 8'h00, 4'h8};
        vecs[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0000_0000_0000_00FF, 64'd1,                   64'h0000_0000_0000_0100, 8'h00, 8'h00, 4'h9};
        vecs[9]  = '{4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 64'd5,                   64'd3,                   64'd1,                   8'h80, 8'h00, 4'hA};
        vecs[10] = '{4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 64'd1,                   64'd1,                   64'd2,                   8'h00, 8'h00, 4'hB};
        vecs[11] = '{4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 64'd0,                   64'd0,                   64'h0100_0100_0001_0001, 8'h00, 8'h00, 4'hC};
        vecs[12] = '{4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1E, 64'd0,                   64'd0,                   64'h0000_0001_0000_0000, 8'h00, 8'h00, 4'hD};

        #12;
        check_val("rst_valid", 64'(bus.valid_o), 64'd0);
        check_val("rst_ready", 64'(bus.ready_o), 64'd1);
        check_val("rst_result", bus.result_o, 64'd0);
        check_val("rst_carry", 64'(bus.carry_o), 64'd0);
        check_val("rst_ovf", 64'(bus.ovf_o), 64'd0);
        check_val("rst_tag", 64'(bus.tag_o), 64'd0);
        check_val("rst_vxsat", 64'(bus.vxsat_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_beat(vecs[i]);
            check_val($sformatf("v%0d_result", i), bus.result_o, vecs[i].res);
            check_val($sformatf("v%0d_carry", i), 64'(bus.carry_o), 64'(vecs[i].cout));
            check_val($sformatf("v%0d_ovf", i), 64'(bus.ovf_o), 64'(vecs[i].ovf));
            check_val($sformatf("v%0d_tag", i), 64'(bus.tag_o), 64'(vecs[i].tag));
            check_val($sformatf("v%0d_vxsat_pre", i), 64'(bus.vxsat_o), 64'(vx_model));
            vx_model = vx_model | (|vecs[i].ovf);
            @(negedge clk);
            check_val($sformatf("v%0d_vxsat_post", i), 64'(bus.vxsat_o), 64'(vx_model));
            check_val($sformatf("v%0d_drained", i), 64'(bus.valid_o), 64'd0);
        end

        // Plain clear of the sticky flag.
        bus.clr_vxsat_i = 1'b1;
        @(negedge clk);
        bus.clr_vxsat_i = 1'b0;
        vx_model = 1'b0;
        check_val("vxsat_clear", 64'(bus.vxsat_o), 64'd0);

        // Back-to-back stream with the consumer stalled for three cycles.
        send_idx   = 0;
        recv_idx   = 0;
        prev_stall = 1'b0;
        snap_res   = 64'd0;
        snap_tag   = 4'd0;
        drive_vec('{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0, 64'h100, 64'd0, 8'h00, 8'h00, 4'h0});
        for (int cyc = 0; cyc < 40 && recv_idx < 6; cyc++) begin
            @(negedge clk);
            bus.ready_i = !(cyc >= 3 && cyc <= 5);
            bus.valid_i = (send_idx < 6);
            bus.opA_i   = 64'(send_idx);
            bus.tag_i   = 4'(send_idx);
            #1;
            if (prev_stall) begin
                check_val("hold_valid", 64'(bus.valid_o), 64'd1);
                check_val("hold_result", bus.result_o, snap_res);
                check_val("hold_tag", 64'(bus.tag_o), 64'(snap_tag));
            end
            if (bus.valid_o && bus.ready_i) begin
                check_val("stream_result", bus.result_o, 64'h100 + 64'(recv_idx));
                check_val("stream_tag", 64'(bus.tag_o), 64'(recv_idx));
                recv_idx++;
            end
            if (bus.valid_i && bus.ready_o) begin
                send_idx++;
            end
            prev_stall = bus.valid_o & ~bus.ready_i;
            snap_res   = bus.result_o;
            snap_tag   = bus.tag_o;
        end
        bus.valid_i = 1'b0;
        check_val("stream_count", 64'(recv_idx), 64'd6);
        @(negedge clk);
        check_val("stream_no_dup", 64'(bus.valid_o), 64'd0);

        // Reset with two beats in flight.
        @(negedge clk);
        drive_vec(vecs[2]);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        @(negedge clk);
        drive_vec(vecs[0]);
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        #1;
        check_val("inflight_valid", 64'(bus.valid_o), 64'd1);
        rst = 1'b1;
        #1;
        check_val("arst_valid", 64'(bus.valid_o), 64'd0);
        check_val("arst_result", bus.result_o, 64'd0);
        check_val("arst_carry", 64'(bus.carry_o), 64'd0);
        check_val("arst_ovf", 64'(bus.ovf_o), 64'd0);
        check_val("arst_tag", 64'(bus.tag_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("post_rst_ready", 64'(bus.ready_o), 64'd1);
        check_val("post_rst_valid", 64'(bus.valid_o), 64'd0);
        bus.ready_i = 1'b1;
        @(negedge clk);
        check_val("discard_s1_a", 64'(bus.valid_o), 64'd0);
        @(negedge clk);
        check_val("discard_s1_b", 64'(bus.valid_o), 64'd0);

        // Clear coinciding with a saturating transfer.
        do_beat(vecs[2]);
        check_val("clr_pri_ovf", 64'(bus.ovf_o), 64'hAA);
        bus.clr_vxsat_i = 1'b1;
        @(negedge clk);
        bus.clr_vxsat_i = 1'b0;
        check_val("clr_priority", 64'(bus.vxsat_o), 64'd0);
        @(negedge clk);
        check_val("clr_hold", 64'(bus.vxsat_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/simd_adder_pipe.md
SIMD_ADDER_PIPE -- requirements
Module: simd_adder_pipe

Interface
REQ-001 SHALL have parameter MIN_WIDTH, default 8, giving the narrowest element/chunk width in bits.
REQ-002 SHALL have parameter MAX_WIDTH, default 64, giving the datapath width; MAX_WIDTH/MIN_WIDTH (RATIO) is a power of two.
REQ-003 SHALL have parameter SEW_WIDTH, default $clog2(RATIO)+1, giving the sew_i width.
REQ-004 SHALL have parameter STAGES, default 2, legal values 1 or 2, giving pipeline depth.
REQ-005 SHALL have parameter TAG_WIDTH, default 4, giving the sideband tag width.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- valid_i  in  1  input beat valid.
- ready_o  out  1  block accepts a beat.
- sub_i  in  1  subtract (A - B).
- rev_i  in  1  swap operands before sub/add.
- carry_i  in  1  use mask_i as per-element carry-in (vadc/vsbc).
- sat_i  in  1  saturating mode.
- signed_i  in  1  signed saturation.
- sew_i  in  SEW_WIDTH  element width select.
- mask_i  in  RATIO  per-chunk carry-in bits.
- opA_i, opB_i  in  MAX_WIDTH  operands.
- tag_i  in  TAG_WIDTH  sideband.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer ready.
- result_o  out  MAX_WIDTH  per-element sum.
- carry_o  out  RATIO  raw carry-out, bit at each element's top chunk.
- ovf_o  out  RATIO  per-element saturation-applied flag, bit at each element's top chunk.
- tag_o  out  TAG_WIDTH  tag of the output beat.
- vxsat_o  out  1  sticky saturation flag.
- clr_vxsat_i  in  1  clear vxsat_o.

Function
REQ-007 SHALL decode sew_i as follows: bit i set selects element width MAX_WIDTH>>i; the highest-index set bit wins; all-zero selects MAX_WIDTH.
REQ-008 SHALL swap A/B when rev_i=1, then invert B when sub_i=1.
REQ-009 SHALL use element carry-in = mask_i bit at element's lowest chunk if carry_i=1 and sat_i=0; else sub_i.
REQ-010 SHALL form result_o per element modulo 2^SEW; carries SHALL never cross element boundaries.
REQ-011 SHALL make carry_o bits at non-top chunks 0; for sub, borrow = ~carry_o.
REQ-012 SHALL, for unsigned saturation (sat_i=1, signed_i=0), clamp add with carry-out=1 to all-ones and sub with carry-out=0 to zero.
REQ-013 SHALL, for signed saturation, detect overflow when sign(A)==sign(B after inversion) and result sign differs, then clamp to 0111..1 if sign(A)=0, else 1000..0.
REQ-014 SHALL set ovf_o for saturated elements only; 0 when sat_i=0.
REQ-015 SHALL give latency exactly STAGES cycles from accepted beat to valid_o; STAGES=2 registers operand prep (swap, invert, carry-in) in stage 1 and add/saturate in stage 2.
REQ-016 SHALL drive ready_o = ~valid_o | ready_i; all stages advance together on (ready_o); a bubble propagates as valid=0.
REQ-017 SHALL accept a beat when valid_i & ready_o; SHALL transfer an output when valid_o & ready_i.
REQ-018 SHALL hold result_o/carry_o/ovf_o/tag_o stable while valid_o=1 & ready_i=0.
REQ-019 SHALL set vxsat_o on the cycle after an output transfer with any ovf_o bit set; otherwise it holds.
REQ-020 SHALL clear vxsat_o on clr_vxsat_i; clear takes priority over a simultaneous set.
REQ-021 SHALL ignore valid_i content when ready_o=0; no beat is lost or duplicated.

Reset
REQ-022 SHALL, while rst=1, asynchronously force all valid bits, result_o, carry_o, ovf_o, tag_o and vxsat_o to 0.
REQ-023 SHALL discard in-flight beats on reset; after release, valid_o=0 and ready_o=1.

Verification
REQ-024 sew=8-bit, opA=0x00FF_00FF_00FF_00FF, opB=0x0001_0001_0001_0001, add -> result 0x0000_...; carry_o=0x55; no carry into odd bytes.
REQ-025 sew=64-bit, sub, rev=1, A=5, B=3 -> result 0xFFFF_FFFF_FFFF_FFFE (3-5); carry_o[7]=0 (borrow).
REQ-026 sew=16-bit, sat signed, A=0x7FF0 per element, B=0x0020 -> 0x7FFF each; ovf_o=0xAA; vxsat_o=1 next cycle after transfer.
REQ-027 carry_i=1, mask=0xFF, sew=32-bit, A=B=0 -> result 0x0000_0001_0000_0001.
REQ-028 STAGES=2, back-to-back beats, ready_i low 3 cycles mid-stream -> outputs in order, none lost/duplicated, held stable.
REQ-029 rst pulsed with 2 beats in flight -> valid_o=0 immediately; clr_vxsat_i with simultaneous saturating transfer -> vxsat_o=0.
